risci_fetch: RTL and testbench

Instruction fetch stage of the risci core: generates sequential instruction addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch queue. Decode consumes the queue head through a valid/ready handshake. The stage tracks in-flight requests so redirects from later stages flush stale instructions without stalling the memory side.

---
 rtl/risci_pkg.sv | 11 +
 rtl/risci_fetch_chk.sv | 20 ++
 rtl/risci_fifo.sv | 66 ++++++
 rtl/risci_fetch.sv | 141 ++++++++++++++
 tb/tb_risci_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risci_pkg.sv
// Shared types and constants for the risci fetch stage.
package risci_pkg;
    localparam int VLEN       = 64;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/risci_fetch_chk.sv
// Protocol checks for the fetch stage: credit overflow and unsolicited responses.
module risci_fetch_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          fifo_push,
    input logic          fifo_pop,
    input logic          fifo_full,
    input logic          rsp_valid,
    input logic [CW-1:0] inflight
);
    // A kept response must always find room once the credit rule holds.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    // Memory may only answer requests it actually accepted.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid && (inflight == '0)));
endmodule

// File: rtl/risci_fifo.sv
// Registered FIFO with synchronous flush. A push into a full queue is only
// accepted when a pop happens in the same cycle.
module risci_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || pop);
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking; flush empties the queue without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage, cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end
endmodule

// File: rtl/risci_fetch.sv
// Instruction fetch stage: sequential address generation, credit-limited issue
// to instruction memory, prefetch queue, and redirect flush with stale-drop.
module risci_fetch #(
    parameter int              VLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [VLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [VLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [VLEN-1:0] redirect_pc,
    input  logic            hlt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [VLEN-1:0] inst_pc
);
    import risci_pkg::INST_BYTES;

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              EW      = VLEN + ILEN;
    localparam logic [VLEN-1:0] STEP    = VLEN'(INST_BYTES);
    localparam logic [VLEN-1:0] PC_RST  = {RESET_PC[VLEN-1:2], 2'b00};
    localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1'b1);

    logic [VLEN-1:0] fetch_pc_r;
    logic [VLEN-1:0] rsp_pc_r;
    logic [VLEN-1:0] fetch_pc_nxt_s;
    logic [VLEN-1:0] rsp_pc_nxt_s;
    logic [VLEN-1:0] redirect_base_s;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   inflight_nxt_s;
    logic [CW-1:0]   discard_nxt_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW:0]     occupancy_s;
    logic            req_fire_s;
    logic            rsp_keep_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [EW-1:0]   push_data_s;
    logic [EW-1:0]   head_s;
    logic            unused_s;

    assign redirect_base_s = {redirect_pc[VLEN-1:2], 2'b00};
    assign unused_s        = ^redirect_pc[1:0];

    // Queued plus in-flight instructions never exceed DEPTH, so a response always fits.
    assign occupancy_s    = {1'b0, fifo_count_s} + {1'b0, inflight_r};
    assign imem_req_valid = rst && !hlt && (occupancy_s < CREDITS);
    assign imem_req_addr  = fetch_pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;

    assign rsp_keep_s  = imem_rsp_valid && !redirect_valid && (discard_r == '0);
    assign pop_s       = inst_valid && inst_ready;
    assign push_data_s = {rsp_pc_r, imem_rsp_data};
    assign inst_valid  = !fifo_empty_s;
    assign inst_pc     = head_s[EW-1:ILEN];
    assign inst_data   = head_s[ILEN-1:0];

    // Next-state for PCs and the in-flight / discard bookkeeping.
    always_comb begin
        inflight_nxt_s = inflight_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
        fetch_pc_nxt_s = fetch_pc_r;
        rsp_pc_nxt_s   = rsp_pc_r;
        discard_nxt_s  = discard_r;
        if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old path.
            fetch_pc_nxt_s = redirect_base_s;
            rsp_pc_nxt_s   = redirect_base_s;
            discard_nxt_s  = inflight_nxt_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_nxt_s = fetch_pc_r + STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (rsp_keep_s) begin
                rsp_pc_nxt_s = rsp_pc_r + STEP;
            end else begin
                rsp_pc_nxt_s = rsp_pc_r;
            end
            if (imem_rsp_valid && (discard_r != '0)) begin
                discard_nxt_s = discard_r - ONE;
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // Fetch-stage state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= PC_RST;
            rsp_pc_r   <= PC_RST;
            inflight_r <= '0;
            discard_r  <= '0;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            rsp_pc_r   <= rsp_pc_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
        end
    end

    risci_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    risci_fetch_chk #(
        .CW (CW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst),
        .fifo_push (rsp_keep_s),
        .fifo_pop  (pop_s),
        .fifo_full (fifo_full_s),
        .rsp_valid (imem_rsp_valid),
        .inflight  (inflight_r)
    );
endmodule

// File: tb/tb_risci_fetch.sv
// Self-checking bench for risci_fetch: randomized memory model plus an
// epoch-tagged scoreboard of the instruction stream decode should observe.
module tb_risci_fetch;
    import risci_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        hlt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    risci_fetch #(
        .VLEN     (64),
        .ILEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hlt            (hlt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           epoch = 0;
    int           cyc = 0;
    int           last_due = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    int           ready_pct = 100;
    int           n_fire = 0;
    int           n_deq = 0;
    logic [63:0]  first_deq_pc;
    logic [63:0]  exp_req = RESET_PC;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // One clock of memory model + scoreboard; called at posedge+1.
    task automatic step_cycle();
        logic        exp_valid;
        logic        fire;
        logic        rsp;
        logic        deq;
        pend_t       p;
        fetch_entry_t e;
        int          lat;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        #2;
        exp_valid = !hlt && ((exp_q.size() + pend_q.size()) < DEPTH);
        n_cmp++;
        if (imem_req_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL req_valid: got %0b want %0b cycle %0d", imem_req_valid, exp_valid, cyc);
        end
        if (imem_req_valid) begin
            n_cmp++;
            if (imem_req_addr !== exp_req) begin
                n_bad++;
                $display("FAIL req_addr: got %h want %h cycle %0d", imem_req_addr, exp_req, cyc);
            end
        end
        n_cmp++;
        if (inst_valid !== (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL inst_valid: got %0b want %0b cycle %0d", inst_valid, exp_q.size() != 0, cyc);
        end
        if (inst_valid && exp_q.size() != 0) begin
            n_cmp++;
            if (inst_pc !== exp_q[0].pc || inst_data !== exp_q[0].inst) begin
                n_bad++;
                $display("FAIL inst_head: got pc %h data %h want pc %h data %h cycle %0d",
                         inst_pc, inst_data, exp_q[0].pc, exp_q[0].inst, cyc);
            end
        end
        fire = imem_req_valid && imem_req_ready;
        rsp  = imem_rsp_valid;
        deq  = inst_valid && inst_ready;
        if (deq && exp_q.size() > 0) begin
            if (n_deq == 0) first_deq_pc = exp_q[0].pc;
            n_deq++;
            void'(exp_q.pop_front());
        end
        if (rsp) begin
            p = pend_q.pop_front();
            if (!redirect_valid && p.epoch == epoch) begin
                e.pc   = p.addr;
                e.inst = word_of(p.addr);
                exp_q.push_back(e);
            end
        end
        if (fire) begin
            lat = int'($urandom_range(lat_max, lat_min));
            if (cyc + lat > last_due) last_due = cyc + lat;
            pend_q.push_back('{addr: exp_req, epoch: epoch, due: last_due});
            n_fire++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            exp_req = {redirect_pc[63:2], 2'b00};
        end else if (fire) begin
            exp_req = exp_req + 64'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic assert_reset();
        #2;
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        pend_q.delete();
        exp_q.delete();
        epoch++;
        last_due = cyc;
        exp_req  = RESET_PC;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic apply_reset();
        assert_reset();
        release_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 64'h0) begin
            n_bad++;
            $display("FAIL %s: got rv %0b ra %h iv %0b id %h ip %h want 0/%h/0/0/0", tag,
                     imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, RESET_PC);
        end
    endtask

    task automatic wait_first_deq(input string tag, input logic [63:0] want);
        n_deq = 0;
        for (int i = 0; i < 40 && n_deq == 0; i++) step_cycle();
        n_cmp++;
        if (n_deq == 0) begin
            n_bad++;
            $display("FAIL %s: timeout got no instruction want pc %h", tag, want);
        end else if (first_deq_pc !== want) begin
            n_bad++;
            $display("FAIL %s: got pc %h want %h", tag, first_deq_pc, want);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        release_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready = 1'b1;
        n_deq = 0;
        for (int i = 0; i < 20; i++) step_cycle();
        n_cmp++;
        if (n_deq != 18 || first_deq_pc !== RESET_PC) begin
            n_bad++;
            $display("FAIL stream: got %0d insts first %h want 18 first %h", n_deq, first_deq_pc, RESET_PC);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready = 1'b0;
        n_fire = 0;
        for (int i = 0; i < 12; i++) step_cycle();
        n_cmp++;
        if (n_fire != DEPTH || imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure: got %0d reqs valid %0b want %0d reqs valid 0", n_fire, imem_req_valid, DEPTH);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) step_cycle();
        n_cmp++;
        if (n_fire < DEPTH + 8) begin
            n_bad++;
            $display("FAIL resume: got %0d reqs want at least %0d", n_fire, DEPTH + 8);
        end
    endtask

    task automatic test_redirect_drop();
        int i;
        apply_reset();
        lat_min = 5; lat_max = 5; ready_pct = 100; inst_ready = 1'b1;
        for (i = 0; i < 20 && !(pend_q.size() == 3 && exp_q.size() == 0); i++) step_cycle();
        n_cmp++;
        if (pend_q.size() != 3) begin
            n_bad++;
            $display("FAIL drop_setup: timeout got %0d in flight want 3", pend_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        step_cycle();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_req_addr !== 64'h1000) begin
            n_bad++;
            $display("FAIL drop_addr: got %h want %h", imem_req_addr, 64'h1000);
        end
        wait_first_deq("drop_pc", 64'h1000);
    endtask

    task automatic test_redirect_collide(input logic [63:0] target);
        int i;
        apply_reset();
        lat_min = 2; lat_max = 2; ready_pct = 100; inst_ready = 1'b1;
        for (i = 0; i < 6; i++) step_cycle();
        for (i = 0; i < 20 && !(pend_q.size() > 0 && pend_q[0].due <= cyc &&
                              (exp_q.size() + pend_q.size()) < DEPTH); i++) step_cycle();
        n_cmp++;
        if (!(pend_q.size() > 0 && pend_q[0].due <= cyc)) begin
            n_bad++;
            $display("FAIL collide_setup: timeout got %0d in flight want a due response", pend_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step_cycle();
        redirect_valid = 1'b0;
        wait_first_deq("collide_pc", {target[63:2], 2'b00});
        for (i = 0; i < 8; i++) step_cycle();
    endtask

    task automatic test_hlt();
        int i;
        apply_reset();
        lat_min = 4; lat_max = 4; ready_pct = 100; inst_ready = 1'b1;
        for (i = 0; i < 10 && pend_q.size() != 2; i++) step_cycle();
        hlt = 1'b1;
        n_fire = 0;
        n_deq  = 0;
        for (i = 0; i < 10; i++) step_cycle();
        n_cmp++;
        if (n_fire != 0 || n_deq != 2) begin
            n_bad++;
            $display("FAIL hlt_drain: got %0d reqs %0d insts want 0 reqs 2 insts", n_fire, n_deq);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        step_cycle();
        redirect_valid = 1'b0;
        for (i = 0; i < 3; i++) step_cycle();
        n_cmp++;
        if (n_fire != 0 || imem_req_addr !== 64'h2000) begin
            n_bad++;
            $display("FAIL hlt_redirect: got %0d reqs addr %h want 0 reqs addr %h", n_fire, imem_req_addr, 64'h2000);
        end
        hlt = 1'b0;
        wait_first_deq("hlt_resume", 64'h2000);
    endtask

    task automatic test_random();
        apply_reset();
        lat_min = 1; lat_max = 6; ready_pct = 60;
        n_deq = 0;
        for (int i = 0; i < 1500; i++) begin
            inst_ready     = ($urandom_range(3) != 0);
            hlt            = ($urandom_range(15) == 0);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = {$urandom, $urandom};
            step_cycle();
        end
        redirect_valid = 1'b0;
        hlt            = 1'b0;
        n_cmp++;
        if (n_deq < 200) begin
            n_bad++;
            $display("FAIL random_progress: got %0d insts want at least 200", n_deq);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        lat_min = 5; lat_max = 5; ready_pct = 100; inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) step_cycle();
        assert_reset();
        #1;
        check_reset_outputs("midstream_reset");
        release_reset();
        wait_first_deq("restart_pc", RESET_PC);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        hlt            = 1'b0;
        inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide(64'h0000_0000_0000_4A6D);
        test_redirect_collide(64'hFFFF_FFFF_FFFF_FFF9);
        test_hlt();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
